// File: rtl/adc_acq_sequencer.sv
// Acquisition sequencer for the SPI ADC manager: config push, mode wait, periodic triggers, drain.
// Optional: define ADC_SEQ_EXT_TRIG_EN to gate the start of acquisition on an ext_trig edge.
module adc_acq_sequencer #(
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned NUM_CFG   = 4,
    localparam int unsigned CfgCntW  = $clog2(NUM_CFG + 1)
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    start,
    input  logic                    stop,
    input  logic [CNT_WIDTH-1:0]    period,
    input  logic [CNT_WIDTH-1:0]    num_samples,
    input  logic [NUM_CFG*32-1:0]   cfg_words,
    input  logic [CfgCntW-1:0]      cfg_count,
    input  logic [31:0]             adc_status,
    input  logic                    cnv_ack,
`ifdef ADC_SEQ_EXT_TRIG_EN
    input  logic                    ext_trig,
`endif
    output logic                    trigger,
    output logic [31:0]             m_axis_cfg_tdata,
    output logic                    m_axis_cfg_tvalid,
    input  logic                    m_axis_cfg_tready,
    output logic                    busy,
    output logic                    done,
    output logic                    overrun,
    output logic [CNT_WIDTH-1:0]    samples_issued,
    output logic [CNT_WIDTH-1:0]    samples_acked
);

    localparam logic [CNT_WIDTH-1:0] CntMax = '1;
    localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CntTwo = CNT_WIDTH'(2);
    localparam logic [CfgCntW-1:0]   CfgMax = CfgCntW'(NUM_CFG);
    localparam logic [CfgCntW-1:0]   CfgOne = CfgCntW'(1);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StCfgSend = 3'd1,
        StCfgWait = 3'd2,
        StAcq     = 3'd3,
        StDrain   = 3'd4
`ifdef ADC_SEQ_EXT_TRIG_EN
        , StWaitExt = 3'd5
`endif
    } state_e;

    state_e               state_q, state_d;
    logic [CfgCntW-1:0]   cfg_idx_q, cfg_idx_d;
    logic [CfgCntW-1:0]   cfg_num_q, cfg_num_d;
    logic                 tvalid_q, tvalid_d;
    logic                 stop_pend_q, stop_pend_d;
    logic                 abort_q, abort_d;
    logic [CNT_WIDTH-1:0] reload_q, reload_d;
    logic [CNT_WIDTH-1:0] num_q, num_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] issued_q, issued_d;
    logic [CNT_WIDTH-1:0] acked_q, acked_d;
    logic                 overrun_q, overrun_d;

    logic        xfer_idle;
    logic        conv_mode;
    logic        slot;
    logic        drain_ok;
    logic [31:0] cfg_word;
    logic        unused_status;

    assign xfer_idle     = (adc_status[1:0] == 2'b00);
    assign conv_mode     = (adc_status[3:2] == 2'b00);
    assign slot          = (cnt_q == '0);
    assign unused_status = ^adc_status[31:5];

    // Finite, unaborted runs must also see every issued sample acknowledged before finishing.
    assign drain_ok = !adc_status[0] && !adc_status[4] &&
                      (abort_q || (num_q == '0) || (acked_q == issued_q));

`ifdef ADC_SEQ_EXT_TRIG_EN
    // Two synchroniser stages plus one history bit for rising-edge detection.
    logic [2:0] ext_sync_q;
    logic       ext_rise;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ext_sync_q <= '0;
        end else begin
            ext_sync_q <= {ext_sync_q[1:0], ext_trig};
        end
    end

    assign ext_rise = ext_sync_q[1] & ~ext_sync_q[2];
`endif

    always_comb begin
        cfg_word = '0;
        for (int unsigned i = 0; i < NUM_CFG; i++) begin
            if (cfg_idx_q == CfgCntW'(i)) begin
                cfg_word = cfg_words[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cfg_idx_d   = cfg_idx_q;
        cfg_num_d   = cfg_num_q;
        tvalid_d    = tvalid_q;
        stop_pend_d = stop_pend_q;
        abort_d     = abort_q;
        reload_d    = reload_q;
        num_d       = num_q;
        cnt_d       = cnt_q;
        issued_d    = issued_q;
        acked_d     = acked_q;
        overrun_d   = overrun_q;
        trigger     = 1'b0;
        done        = 1'b0;

        if ((state_q != StIdle) && cnv_ack && (acked_q != CntMax)) begin
            acked_d = acked_q + CntOne;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    reload_d    = (period < CntTwo) ? CntOne : (period - CntOne);
                    num_d       = num_samples;
                    cfg_num_d   = (cfg_count > CfgMax) ? CfgMax : cfg_count;
                    cfg_idx_d   = '0;
                    issued_d    = '0;
                    acked_d     = '0;
                    overrun_d   = 1'b0;
                    stop_pend_d = 1'b0;
                    abort_d     = 1'b0;
                    if (cfg_count != '0) begin
                        tvalid_d = 1'b1;
                        state_d  = StCfgSend;
                    end else begin
                        state_d  = StCfgWait;
                    end
                end
            end

            StCfgSend: begin
                // A stop must not withdraw an offered word; remember it until the handshake.
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (m_axis_cfg_tready) begin
                    cfg_idx_d = cfg_idx_q + CfgOne;
                    if (stop || stop_pend_q) begin
                        tvalid_d = 1'b0;
                        abort_d  = 1'b1;
                        state_d  = StDrain;
                    end else if ((cfg_idx_q + CfgOne) == cfg_num_q) begin
                        tvalid_d = 1'b0;
                        state_d  = StCfgWait;
                    end
                end
            end

            StCfgWait: begin
                if (stop) begin
                    abort_d = 1'b1;
                    state_d = StDrain;
                end else if (xfer_idle && conv_mode) begin
`ifdef ADC_SEQ_EXT_TRIG_EN
                    state_d = StWaitExt;
`else
                    cnt_d   = '0;
                    state_d = StAcq;
`endif
                end
            end

`ifdef ADC_SEQ_EXT_TRIG_EN
            StWaitExt: begin
                if (stop) begin
                    abort_d = 1'b1;
                    state_d = StDrain;
                end else if (ext_rise) begin
                    cnt_d   = '0;
                    state_d = StAcq;
                end
            end
`endif

            StAcq: begin
                // The counter enters at zero so the first slot lands on the first ACQ cycle.
                cnt_d = slot ? reload_q : (cnt_q - CntOne);
                if (stop) begin
                    abort_d = 1'b1;
                    state_d = StDrain;
                end else if ((num_q != '0) && (issued_q == num_q)) begin
                    state_d = StDrain;
                end else if (slot) begin
                    if (!adc_status[0] && conv_mode) begin
                        trigger = 1'b1;
                        if (issued_q != CntMax) begin
                            issued_d = issued_q + CntOne;
                        end
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end

            StDrain: begin
                // A stop here releases a finite run that is stuck waiting on lost acks.
                if (stop) begin
                    abort_d = 1'b1;
                end
                if (drain_ok) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end

            default: begin
                tvalid_d = 1'b0;
                state_d  = StIdle;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= StIdle;
            cfg_idx_q   <= '0;
            cfg_num_q   <= '0;
            tvalid_q    <= 1'b0;
            stop_pend_q <= 1'b0;
            abort_q     <= 1'b0;
            reload_q    <= '0;
            num_q       <= '0;
            cnt_q       <= '0;
            issued_q    <= '0;
            acked_q     <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_idx_q   <= cfg_idx_d;
            cfg_num_q   <= cfg_num_d;
            tvalid_q    <= tvalid_d;
            stop_pend_q <= stop_pend_d;
            abort_q     <= abort_d;
            reload_q    <= reload_d;
            num_q       <= num_d;
            cnt_q       <= cnt_d;
            issued_q    <= issued_d;
            acked_q     <= acked_d;
            overrun_q   <= overrun_d;
        end
    end

    assign busy              = (state_q != StIdle);
    assign m_axis_cfg_tvalid = tvalid_q;
    assign m_axis_cfg_tdata  = tvalid_q ? cfg_word : 32'h0;
    assign overrun           = overrun_q;
    assign samples_issued    = issued_q;
    assign samples_acked     = acked_q;

endmodule
